write_group_packer: RTL and testbench
=====================================

Name: write_group_packer

Overview:
- Upstream stage of the multi-write circular FIFO.
- Accepts one NUM_BIT word per cycle from a serial producer (valid/ready).
- Gathers PAR_WRITE words into one wide group and presents it to the FIFO write port with a lane mask.
- Holds the group under FIFO backpressure; supports flush of a partial group so the FIFO write pointer can advance by a full PAR_WRITE step.

Parameters:
- NUM_BIT, 4: width of one data word.
- PAR_WRITE, 2: words per FIFO write (lanes per group); must be >= 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset.
- in_data, input, NUM_BIT: producer word.
- in_valid, input, 1: producer word valid.
- in_ready, output, 1: packer can accept in_data this cycle.
- flush, input, 1: close the current partial group.
- out_data, output, PAR_WRITE*NUM_BIT: packed group; lane i at bits [i*NUM_BIT +: NUM_BIT].
- out_mask, output, PAR_WRITE: per-lane valid bits of out_data.
- out_valid, output, 1: group presented to FIFO.
- out_ready, input, 1: FIFO has room for one group (FIFO READY comparator result).

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high and after release: state COLLECT, fill count 0, out_valid 0, out_mask 0, out_data 0, in_ready 1.
- Fill counter: width $clog2(PAR_WRITE+1), range 0..PAR_WRITE.
- States:
  - COLLECT: out_valid=0.
  - PRESENT: out_valid=1; out_data and out_mask registered and stable.
- Accept: in_valid && in_ready.
  - The word is written to lane[count]; count increments.
  - Lanes fill LSB-first (lane 0 first).
- COLLECT -> PRESENT when either:
  - an accept makes count == PAR_WRITE (out_mask all ones), or
  - flush is high with count > 0 after the cycle's accept. out_mask has the low count bits set; unfilled lanes are driven 0.
- Flush with count 0 and no accept: ignored; no output.
- Flush in the same cycle as an accept: the accepted word is included in the flushed group.
- Flush while in PRESENT: ignored.
- Latency: out_valid rises on the clock edge that completes or flushes the group (one cycle after the final accept).
- Transfer: out_valid && out_ready. On the transfer edge, out_valid drops unless a new group completes in the same cycle. Lanes and count clear; an accept in the same cycle lands in lane 0 (count becomes 1).
- in_ready = (state == COLLECT) || out_ready. This is a combinational path from out_ready and gives zero-bubble streaming at one word per cycle.
- PAR_WRITE == 1: every accept goes straight to PRESENT with mask 1; flush has no effect.
- Backpressure: out_valid held high, out_data and out_mask unchanged, in_ready 0 until out_ready.
- Reset mid-group: the partial group is discarded with no output; the next accepted word fills lane 0.

Decomposition:
- shared_params.vh holds NUM_BIT, PAR_WRITE and the COLLECT/PRESENT state encoding localparams.
- One natural sub-module: packer_fill_counter. It is an init/inc counter, 0..PAR_WRITE, with async reset, in the same style as the FIFO pointer counters.
- The lane register file and mask generation stay in the top-level module.

Test Plan:
- Reset: pulse rst mid-clock -> immediately out_valid=0, out_mask=2'b00, out_data=8'h00, in_ready=1.
- Full group: NUM_BIT=4, PAR_WRITE=2, out_ready=1; accept 4'hA then 4'h5 -> next cycle out_valid=1, out_data=8'h5A, out_mask=2'b11; transferred that cycle.
- Backpressure: group 8'h5A with out_ready=0 for 3 cycles -> in_ready=0, out_data steady. Then out_ready=1 with in_data=4'h3 valid -> group transferred, 4'h3 in lane 0, count=1.
- Partial flush: accept 4'h7, then flush -> out_data=8'h07, out_mask=2'b01. Flush at count 0 -> out_valid stays 0.
- Flush plus accept: count=1 holding 4'h1; flush with in_data=4'h2 accepted -> out_data=8'h21, out_mask=2'b11.
- Reset mid-group: count=1, assert rst -> no output. After release, accept 4'h9 then 4'h4 -> out_data=8'h49.

Source files
------------

// File: rtl/write_group_packer_pkg.sv
// Shared parameters and state encoding for the write-group packer.
package write_group_packer_pkg;
    localparam int NUM_BIT_DEF   = 4;
    localparam int PAR_WRITE_DEF = 2;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } pk_state_t;
endpackage

// File: rtl/write_group_packer_fill_counter.sv
// Fill counter 0..MAX: init clears it, and an init+inc together loads 1.
module packer_fill_counter #(
    parameter int MAX = 2,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic          i_inc,
    output logic [CW-1:0] o_count
);
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_count <= '0;
        else if (i_init) r_count <= CW'(i_inc);
        else if (i_inc)  r_count <= r_count + CW'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/write_group_packer.sv
// Gathers PAR_WRITE serial words into one masked group for the multi-write FIFO.
module write_group_packer
    import write_group_packer_pkg::*;
#(
    parameter int NUM_BIT   = NUM_BIT_DEF,
    parameter int PAR_WRITE = PAR_WRITE_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BIT-1:0]           in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [PAR_WRITE*NUM_BIT-1:0] out_data,
    output logic [PAR_WRITE-1:0]         out_mask,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int CW = $clog2(PAR_WRITE + 1);

    pk_state_t                           r_state;
    logic [PAR_WRITE-1:0][NUM_BIT-1:0]   r_lanes;
    logic [PAR_WRITE-1:0]                r_mask;

    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_base;
    logic [CW-1:0]        w_new_cnt;
    logic                 w_xfer;
    logic                 w_acc;
    logic                 w_full;
    logic                 w_flush_go;
    logic                 w_go;
    logic [PAR_WRITE-1:0] w_mask_nxt;

    assign in_ready  = (r_state == COLLECT) || out_ready;
    assign w_xfer    = (r_state == PRESENT) && out_ready;
    assign w_acc     = in_valid && in_ready;
    // A transfer frees the lanes, so a same-cycle accept lands in lane 0.
    assign w_base    = w_xfer ? '0 : w_count;
    assign w_new_cnt = w_base + CW'(w_acc);
    assign w_full    = w_acc && (w_new_cnt == CW'(PAR_WRITE));
    assign w_flush_go = flush && (r_state == COLLECT) && (w_new_cnt != '0);
    assign w_go      = w_full || w_flush_go;

    always_comb begin
        w_mask_nxt = '0;
        for (int i = 0; i < PAR_WRITE; i++)
            w_mask_nxt[i] = (CW'(i) < w_new_cnt);
    end

    packer_fill_counter #(.MAX(PAR_WRITE), .CW(CW)) u_fill (
        .clk     (clk),
        .rst     (rst),
        .i_init  (w_xfer),
        .i_inc   (w_acc),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
            r_lanes <= '0;
            r_mask  <= '0;
        end else begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                if (w_xfer)
                    r_lanes[i] <= (w_acc && i == 0) ? in_data : '0;
                else if (w_acc && CW'(i) == w_count)
                    r_lanes[i] <= in_data;
            end
            if (w_go) begin
                r_state <= PRESENT;
                r_mask  <= w_mask_nxt;
            end else if (w_xfer) begin
                r_state <= COLLECT;
                r_mask  <= '0;
            end
        end
    end

    assign out_data  = r_lanes;
    assign out_mask  = r_mask;
    assign out_valid = (r_state == PRESENT);
endmodule

// File: tb/tb_write_group_packer.sv
// Directed and randomized checks of write_group_packer against a queue-based group model.
module tb_write_group_packer;
    localparam int NB = 4;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [PW*NB-1:0]  out_data;
    logic [PW-1:0]     out_mask;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model: words gathered so far, plus the group currently offered.
    logic [NB-1:0]    pend[$];
    logic             m_valid = 1'b0;
    logic [PW*NB-1:0] m_data = '0;
    logic [PW-1:0]    m_mask = '0;

    always #5 clk = ~clk;

    write_group_packer #(.NUM_BIT(NB), .PAR_WRITE(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_mask  = '0;
    endtask

    task automatic step(input logic v, input logic [NB-1:0] d, input logic f, input logic r);
        bit acc, pres0;
        in_valid = v; in_data = d; flush = f; out_ready = r;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || r));
        acc   = v && (!m_valid || r);
        pres0 = m_valid;
        if (m_valid && r) m_valid = 1'b0;
        if (acc) pend.push_back(d);
        if (pend.size() == PW || (f && !pres0 && pend.size() > 0)) begin
            m_data = '0;
            foreach (pend[i]) m_data[i*NB +: NB] = pend[i];
            m_mask  = PW'((1 << pend.size()) - 1);
            m_valid = 1'b1;
            pend.delete();
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_mask", 32'(out_mask), 32'(m_mask));
        end
    endtask

    initial begin
        // Reset asserted mid-clock: outputs must clear immediately.
        #3;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_mask",  32'(out_mask),  32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Full group
        step(1, 4'hA, 0, 1);
        step(1, 4'h5, 0, 1);
        chk("full_data", 32'(out_data), 32'h5A);
        chk("full_mask", 32'(out_mask), 32'h3);

        // Backpressure, then transfer with a same-cycle accept into lane 0
        step(0, 4'h0, 0, 0);
        step(0, 4'h0, 0, 0);
        step(0, 4'h0, 0, 0);
        chk("bp_data", 32'(out_data), 32'h5A);
        step(1, 4'h3, 0, 1);
        step(0, 4'h0, 1, 1);
        chk("lane0_data", 32'(out_data), 32'h03);
        chk("lane0_mask", 32'(out_mask), 32'h1);
        step(0, 4'h0, 0, 1);

        // Partial flush, then flush at count 0
        step(1, 4'h7, 0, 1);
        step(0, 4'h0, 1, 1);
        chk("pflush_data", 32'(out_data), 32'h07);
        chk("pflush_mask", 32'(out_mask), 32'h1);
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 1, 1);
        chk("flush0_valid", 32'(out_valid), 32'd0);

        // Flush together with an accept
        step(1, 4'h1, 0, 1);
        step(1, 4'h2, 1, 1);
        chk("fa_data", 32'(out_data), 32'h21);
        chk("fa_mask", 32'(out_mask), 32'h3);
        step(0, 4'h0, 0, 1);

        // Reset mid-group discards the partial word
        step(1, 4'h8, 0, 1);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        step(1, 4'h9, 0, 1);
        chk("mrst_novalid", 32'(out_valid), 32'd0);
        step(1, 4'h4, 0, 1);
        chk("mrst_data", 32'(out_data), 32'h49);

        // Randomized traffic
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 3) != 0), NB'($urandom),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
